i2c_target: RTL and testbench

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 221 ++++++++++++++++++++++
 tb/tb_i2c_target.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, receives write bytes and returns read bytes.
// Build option: define I2C_TARGET_GEN_CALL_EN to also accept general-call writes (address byte 8'h00).
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } state_t;

  logic       scl_meta_r, scl_sync_r, scl_prev_r;
  logic       sda_meta_r, sda_sync_r, sda_prev_r;
  logic       scl_rise_s, scl_fall_s, start_s, stop_s;
  state_t     state_r, state_nxt_s;
  logic [3:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0] shift_r, shift_nxt_s;
  logic [7:0] tx_shift_r, tx_shift_nxt_s;
  logic [7:0] rx_data_r, rx_data_nxt_s;
  logic       rx_valid_r, rx_valid_nxt_s;
  logic       tx_req_r, tx_req_nxt_s;
  logic       sda_oe_r, sda_oe_nxt_s;
  logic       busy_r, busy_nxt_s;
  logic       addr_match_s;
  logic [7:0] byte_in_s;

  assign scl_rise_s = scl_sync_r & ~scl_prev_r;
  assign scl_fall_s = ~scl_sync_r & scl_prev_r;
  assign start_s    = scl_sync_r & scl_prev_r & sda_prev_r & ~sda_sync_r;
  assign stop_s     = scl_sync_r & scl_prev_r & ~sda_prev_r & sda_sync_r;
  assign byte_in_s  = {shift_r[6:0], sda_sync_r};

  // Two-flop synchronizers plus one history stage for edge detection; reset to an idle bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_meta_r <= 1'b1;
      scl_sync_r <= 1'b1;
      scl_prev_r <= 1'b1;
      sda_meta_r <= 1'b1;
      sda_sync_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_meta_r <= scl_i;
      scl_sync_r <= scl_meta_r;
      scl_prev_r <= scl_sync_r;
      sda_meta_r <= sda_i;
      sda_sync_r <= sda_meta_r;
      sda_prev_r <= sda_sync_r;
    end
  end

  // Address comparison on the shifted-in address byte (bit 0 is R/W).
  always_comb begin
    addr_match_s = 1'b0;
    if (shift_r[7:1] == TARGET_ADDR) begin
      addr_match_s = 1'b1;
`ifdef I2C_TARGET_GEN_CALL_EN
    end else if (shift_r == 8'h00) begin
      addr_match_s = 1'b1;
`endif
    end else begin
      addr_match_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; START and STOP override every state.
  always_comb begin
    state_nxt_s = state_r;
    if (start_s) begin
      state_nxt_s = ADDR;
    end else if (stop_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        ADDR: begin
          if (scl_fall_s && (bit_cnt_r == 4'd8)) state_nxt_s = addr_match_s ? ADDR_ACK : IGNORE;
          else state_nxt_s = ADDR;
        end
        ADDR_ACK: begin
          if (scl_fall_s) state_nxt_s = shift_r[0] ? RD_DATA : WR_DATA;
          else state_nxt_s = ADDR_ACK;
        end
        WR_DATA: begin
          if (scl_fall_s && (bit_cnt_r == 4'd8)) state_nxt_s = WR_ACK;
          else state_nxt_s = WR_DATA;
        end
        WR_ACK: begin
          if (scl_fall_s) state_nxt_s = WR_DATA;
          else state_nxt_s = WR_ACK;
        end
        RD_DATA: begin
          if (scl_fall_s && (bit_cnt_r == 4'd8)) state_nxt_s = RD_ACK;
          else state_nxt_s = RD_DATA;
        end
        RD_ACK: begin
          // A NACK ends the read at the rising edge; an ACK continues at the falling edge.
          if (scl_rise_s && sda_sync_r) state_nxt_s = IGNORE;
          else if (scl_fall_s) state_nxt_s = RD_DATA;
          else state_nxt_s = RD_ACK;
        end
        IDLE:    state_nxt_s = IDLE;
        IGNORE:  state_nxt_s = IGNORE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // FSM output and datapath next values; sda_oe follows the next state so it moves only after SCL falls.
  always_comb begin
    bit_cnt_nxt_s  = bit_cnt_r;
    shift_nxt_s    = shift_r;
    tx_shift_nxt_s = tx_shift_r;
    rx_data_nxt_s  = rx_data_r;
    rx_valid_nxt_s = 1'b0;
    tx_req_nxt_s   = 1'b0;
    if (start_s || stop_s) begin
      bit_cnt_nxt_s = 4'd0;
    end else begin
      case (state_r)
        ADDR, WR_DATA: begin
          if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
            shift_nxt_s   = byte_in_s;
            bit_cnt_nxt_s = bit_cnt_r + 4'd1;
            if ((state_r == WR_DATA) && (bit_cnt_r == 4'd7)) begin
              rx_data_nxt_s  = byte_in_s;
              rx_valid_nxt_s = 1'b1;
            end else begin
              rx_valid_nxt_s = 1'b0;
            end
          end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
            bit_cnt_nxt_s = 4'd0;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r;
          end
        end
        ADDR_ACK: begin
          if (scl_rise_s && shift_r[0]) tx_req_nxt_s = 1'b1;
          else if (scl_fall_s && shift_r[0]) tx_shift_nxt_s = tx_data;
          else tx_req_nxt_s = 1'b0;
        end
        RD_DATA: begin
          if (scl_rise_s && (bit_cnt_r < 4'd8)) bit_cnt_nxt_s = bit_cnt_r + 4'd1;
          else if (scl_fall_s && (bit_cnt_r == 4'd8)) bit_cnt_nxt_s = 4'd0;
          else if (scl_fall_s) tx_shift_nxt_s = {tx_shift_r[6:0], 1'b0};
          else bit_cnt_nxt_s = bit_cnt_r;
        end
        RD_ACK: begin
          if (scl_rise_s && !sda_sync_r) tx_req_nxt_s = 1'b1;
          else if (scl_fall_s) tx_shift_nxt_s = tx_data;
          else tx_req_nxt_s = 1'b0;
        end
        default: bit_cnt_nxt_s = bit_cnt_r;
      endcase
    end
    case (state_nxt_s)
      ADDR_ACK, WR_ACK: sda_oe_nxt_s = 1'b1;
      RD_DATA:          sda_oe_nxt_s = ~tx_shift_nxt_s[7];
      default:          sda_oe_nxt_s = 1'b0;
    endcase
    case (state_nxt_s)
      ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK: busy_nxt_s = 1'b1;
      default:                                  busy_nxt_s = 1'b0;
    endcase
  end

  // Registered outputs and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r  <= 4'd0;
      shift_r    <= 8'h00;
      tx_shift_r <= 8'h00;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      tx_req_r   <= 1'b0;
      sda_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      bit_cnt_r  <= bit_cnt_nxt_s;
      shift_r    <= shift_nxt_s;
      tx_shift_r <= tx_shift_nxt_s;
      rx_data_r  <= rx_data_nxt_s;
      rx_valid_r <= rx_valid_nxt_s;
      tx_req_r   <= tx_req_nxt_s;
      sda_oe_r   <= sda_oe_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  assign sda_oe   = sda_oe_r;
  assign rx_data  = rx_data_r;
  assign rx_valid = rx_valid_r;
  assign tx_req   = tx_req_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: bit-banged bus master plus a transaction-level expectation model.
module tb_i2c_target;
  localparam logic [6:0] TADDR = 7'h50;
  localparam int M_NONE = 0, M_WR = 1, M_RD = 2, M_IGN = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m, sda_m;
  logic       sda_line;
  logic       sda_oe, rx_valid, tx_req, busy;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;

  int checks = 0;
  int errors = 0;
  logic [7:0] tx_list [4];
  int tx_idx = 0;
  int rx_cnt = 0;
  int tx_req_cnt = 0;
  int exp_tx_req = 0;
  int model_rd_idx = 0;
  int mode = M_NONE;
  logic chk_win = 1'b0;
  logic exp_oe = 1'b0;
  logic exp_busy = 1'b0;
  logic [7:0] exp_rx_q [$];

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_target #(.TARGET_ADDR(TADDR)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_line), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
  );

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare process: line behaviour in SCL-high windows, every write strobe against the model queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_win) begin
        check("sda_oe", sda_oe, exp_oe);
        check("busy", busy, exp_busy);
      end
      if (rx_valid) begin
        rx_cnt++;
        if (exp_rx_q.size() == 0) check("rx_valid_unexpected", rx_valid, 1'b0);
        else check("rx_data", rx_data, exp_rx_q.pop_front());
      end
      if (tx_req) tx_req_cnt++;
    end
  end

  // Application side: hand out the next read byte on every tx_req.
  always @(negedge clk) begin
    if (rst_n && tx_req) begin
      if (tx_idx < 4) tx_data = tx_list[tx_idx];
      else tx_data = 8'hFF;
      tx_idx++;
    end
  end

  task automatic bus_bit(input logic b, input logic e_oe, input logic e_busy, output logic seen);
    wait_clk(4); sda_m = b;
    wait_clk(6); scl_m = 1'b1;
    wait_clk(5); exp_oe = e_oe; exp_busy = e_busy; chk_win = 1'b1;
    wait_clk(4); seen = sda_line; chk_win = 1'b0;
    wait_clk(1); scl_m = 1'b0;
  endtask

  task automatic do_start();
    wait_clk(4); sda_m = 1'b1;
    wait_clk(6); scl_m = 1'b1;
    wait_clk(10); sda_m = 1'b0;
    wait_clk(10); scl_m = 1'b0;
    mode = M_NONE;
  endtask

  task automatic do_stop();
    wait_clk(4); sda_m = 1'b0;
    wait_clk(6); scl_m = 1'b1;
    wait_clk(10); sda_m = 1'b1;
    wait_clk(10);
    mode = M_NONE;
    check("busy_after_stop", busy, 1'b0);
    check("oe_after_stop", sda_oe, 1'b0);
  endtask

  task automatic send_addr(input logic [7:0] a, output logic acked);
    logic match, seen;
    match = (a[7:1] == TADDR);
`ifdef I2C_TARGET_GEN_CALL_EN
    if (a == 8'h00) match = 1'b1;
`endif
    for (int i = 7; i >= 0; i--) bus_bit(a[i], 1'b0, 1'b0, seen);
    if (match && a[0]) begin model_rd_idx++; exp_tx_req++; end
    bus_bit(1'b1, match, match, seen);
    acked = ~seen;
    mode = !match ? M_IGN : (a[0] ? M_RD : M_WR);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic acked);
    logic w, seen;
    w = (mode == M_WR);
    if (w) exp_rx_q.push_back(d);
    for (int i = 7; i >= 0; i--) bus_bit(d[i], 1'b0, w, seen);
    bus_bit(1'b1, w, w, seen);
    acked = ~seen;
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic r, seen;
    logic [7:0] e;
    r = (mode == M_RD);
    e = (r && model_rd_idx > 0) ? tx_list[model_rd_idx-1] : 8'hFF;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r ? ~e[i] : 1'b0, r, seen);
      d[i] = seen;
    end
    if (r && mack) begin model_rd_idx++; exp_tx_req++; end
    bus_bit(~mack, 1'b0, r && mack, seen);
    if (r && !mack) mode = M_IGN;
  endtask

  initial begin
    logic ack;
    logic [7:0] d;
    logic seen;
    int rx0, tx0;
    tx_list[0] = 8'h3C; tx_list[1] = 8'hC3; tx_list[2] = 8'h5A; tx_list[3] = 8'hE1;
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(3);
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_tx_req", tx_req, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    rst_n = 1'b1;
    wait_clk(3);

    // Plain write of 0xA5.
    rx0 = rx_cnt;
    do_start(); send_addr(8'hA0, ack); check("w_addr_ack", ack, 1'b1);
    send_byte(8'hA5, ack); check("w_data_ack", ack, 1'b1);
    do_stop();
    check("w_rx_data", rx_data, 8'hA5);
    check("w_rx_cnt", rx_cnt - rx0, 8'd1);

    // Wrong address: never acknowledged, nothing received.
    rx0 = rx_cnt;
    do_start(); send_addr(8'hA2, ack); check("miss_addr_ack", ack, 1'b0);
    send_byte(8'h33, ack); check("miss_data_ack", ack, 1'b0);
    do_stop();
    check("miss_rx_cnt", rx_cnt - rx0, 8'd0);

    // Read two bytes, master ACK then NACK.
    tx0 = tx_req_cnt;
    do_start(); send_addr(8'hA1, ack); check("r_addr_ack", ack, 1'b1);
    recv_byte(1'b1, d); check("r_byte0", d, 8'h3C);
    recv_byte(1'b0, d); check("r_byte1", d, 8'hC3);
    do_stop();
    check("r_tx_req_cnt", tx_req_cnt - tx0, 8'd2);

    // Write then repeated START into a read.
    tx0 = tx_req_cnt;
    do_start(); send_addr(8'hA0, ack); send_byte(8'h11, ack);
    check("rs_rx_data", rx_data, 8'h11);
    do_start(); send_addr(8'hA1, ack); check("rs_addr_ack", ack, 1'b1);
    check("rs_tx_req", tx_req_cnt - tx0, 8'd1);
    recv_byte(1'b0, d); check("rs_byte", d, 8'h5A);
    do_stop();

    // Reset while the target is pulling SDA low in the fourth read bit.
    do_start(); send_addr(8'hA1, ack);
    for (int i = 7; i >= 5; i--) bus_bit(1'b1, ~tx_list[3][i], 1'b1, seen);
    wait_clk(6); scl_m = 1'b1;
    wait_clk(5);
    check("pre_rst_oe", sda_oe, 1'b1);
    #2 rst_n = 1'b0;
    #1 check("async_rst_oe", sda_oe, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    mode = M_NONE;
    wait_clk(3); rst_n = 1'b1;
    wait_clk(3);
    check("post_rst_rx_data", rx_data, 8'h00);
    do_start(); send_addr(8'hA0, ack); check("pr_addr_ack", ack, 1'b1);
    send_byte(8'h7E, ack); check("pr_data_ack", ack, 1'b1);
    do_stop();
    check("pr_rx_data", rx_data, 8'h7E);

    // General call write.
    do_start(); send_addr(8'h00, ack);
`ifdef I2C_TARGET_GEN_CALL_EN
    check("gc_addr_ack", ack, 1'b1);
    send_byte(8'h06, ack); check("gc_data_ack", ack, 1'b1);
    do_stop(); check("gc_rx_data", rx_data, 8'h06);
`else
    check("gc_addr_ack", ack, 1'b0);
    send_byte(8'h06, ack); check("gc_data_ack", ack, 1'b0);
    do_stop(); check("gc_rx_data", rx_data, 8'h7E);
`endif

    check("tx_req_total", tx_req_cnt[7:0], exp_tx_req[7:0]);
    check("rx_q_drained", exp_rx_q.size(), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
